// File: rtl/sequence_generator_if.sv
// Handshake and serial-line bundle between a pattern requester and the
// sequence_generator. The master side requests transmissions; the slave
// side (the generator) drives the serial line and status flags.
interface sequence_generator_if #(
    parameter int REP_W = 4
);
    logic             start;
    logic [REP_W-1:0] reps;
    logic             out;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output reps,
        input  out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  reps,
        output out,
        output busy,
        output done
    );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends PATTERN MSB first, followed by GAP
// idle-high cycles, repeated a requested number of times. The line rests
// high so a downstream "011" recognizer sits in its initial state between
// patterns. All outputs are registered.
module sequence_generator #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b011,
    parameter int               GAP     = 4,
    parameter int               REP_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    sequence_generator_if.slave bus
);

    localparam int BIT_W = $clog2(PAT_W + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(PAT_W);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [BIT_W-1:0] bitcnt_q, bitcnt_d;   // pattern bits left, including the one on the line
    logic [GAP_W-1:0] gapcnt_q, gapcnt_d;   // gap cycles left, including the current one
    logic [REP_W-1:0] repcnt_q, repcnt_d;   // repetitions left, including the current one
    logic [PAT_W-1:0] shreg_q,  shreg_d;    // pattern bits, current bit at the MSB
    logic             out_q,    out_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             load_pat;

    // Next-state logic: walk pattern bits, then gap cycles, then repeat or finish.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        repcnt_d = repcnt_q;
        shreg_d  = shreg_q;
        out_d    = out_q;
        load_pat = 1'b0;

        case (state_q)
            ST_IDLE: begin
                out_d = 1'b1;
                if (bus.start) begin
                    // A zero request still sends one pattern, so REPCNT never holds 0 while busy.
                    repcnt_d = (bus.reps == '0) ? REP_ONE : bus.reps;
                    load_pat = 1'b1;
                end
            end

            ST_SEND: begin
                if (bitcnt_q > BIT_ONE) begin
                    bitcnt_d = bitcnt_q - BIT_ONE;
                    shreg_d  = shreg_q << 1;
                    out_d    = shreg_d[PAT_W-1];
                end else begin
                    // LSB has been on the line for its cycle.
                    bitcnt_d = '0;
                    if (GAP > 0) begin
                        state_d  = ST_GAP;
                        gapcnt_d = GAP_LOAD;
                        out_d    = 1'b1;
                    end else if (repcnt_q > REP_ONE) begin
                        repcnt_d = repcnt_q - REP_ONE;
                        load_pat = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        repcnt_d = '0;
                        out_d    = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                out_d = 1'b1;
                if (gapcnt_q > GAP_ONE) begin
                    gapcnt_d = gapcnt_q - GAP_ONE;
                end else begin
                    gapcnt_d = '0;
                    if (repcnt_q > REP_ONE) begin
                        repcnt_d = repcnt_q - REP_ONE;
                        load_pat = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        repcnt_d = '0;
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                bitcnt_d = '0;
                gapcnt_d = '0;
                repcnt_d = '0;
                out_d    = 1'b1;
            end
        endcase

        // Starting a pattern puts its MSB on the line at the same edge.
        if (load_pat) begin
            state_d  = ST_SEND;
            bitcnt_d = BIT_LOAD;
            shreg_d  = PATTERN;
            out_d    = PATTERN[PAT_W-1];
        end

        // Status flags follow the next state so they line up with the registered data.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any transmission without a done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            repcnt_q <= '0;
            shreg_q  <= '0;
            out_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            repcnt_q <= repcnt_d;
            shreg_q  <= shreg_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.out  = out_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: a default instance (011, gap 4)
// and a variant instance (1010, no gap), compared cycle by cycle against an
// expected waveform built from the pattern/gap/repeat rules.
module tb_sequence_generator;

    localparam int REP_W = 4;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   exp_q[$];

    always #5 clock = ~clock;

    sequence_generator_if #(.REP_W(REP_W)) bus_a ();
    sequence_generator_if #(.REP_W(REP_W)) bus_b ();

    sequence_generator #(
        .PAT_W(3), .PATTERN(3'b011), .GAP(4), .REP_W(REP_W)
    ) dut_a (
        .clock(clock), .reset(reset), .bus(bus_a)
    );

    sequence_generator #(
        .PAT_W(4), .PATTERN(4'b1010), .GAP(0), .REP_W(REP_W)
    ) dut_b (
        .clock(clock), .reset(reset), .bus(bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_start(input int sel, input logic st);
        if (sel == 0) bus_a.start = st;
        else          bus_b.start = st;
    endtask

    task automatic set_reps(input int sel, input logic [REP_W-1:0] r);
        if (sel == 0) bus_a.reps = r;
        else          bus_b.reps = r;
    endtask

    // {out, busy, done}
    function automatic logic [2:0] obs3(input int sel);
        if (sel == 0) return {bus_a.out, bus_a.busy, bus_a.done};
        return {bus_b.out, bus_b.busy, bus_b.done};
    endfunction

    // Expected line: N copies of (pattern MSB first, then GAP ones).
    function automatic void build_expected(input int sel, input int r);
        int pw, pat, gap, n;
        pw  = (sel == 0) ? 3 : 4;
        pat = (sel == 0) ? 'b011 : 'b1010;
        gap = (sel == 0) ? 4 : 0;
        n   = (r == 0) ? 1 : r;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            for (int b = pw - 1; b >= 0; b--) exp_q.push_back(bit'((pat >> b) & 1));
            for (int g = 0; g < gap; g++) exp_q.push_back(1'b1);
        end
    endfunction

    // Called at a negedge; ends at the negedge of the done cycle.
    // With hold=1, start stays high through busy and the done cycle.
    task automatic run_tx(input int sel, input int r, input logic hold);
        int len;
        build_expected(sel, r);
        len = exp_q.size();
        set_start(sel, 1'b1);
        set_reps(sel, REP_W'(r));
        for (int i = 0; i < len; i++) begin
            @(negedge clock);
            chk($sformatf("tx%0d_r%0d_c%0d", sel, r, i), {29'd0, obs3(sel)}, {29'd0, exp_q[i], 2'b10});
            set_start(sel, hold);
            set_reps(sel, REP_W'($urandom));
        end
        @(negedge clock);
        chk($sformatf("done%0d_r%0d", sel, r), {29'd0, obs3(sel)}, {29'd0, 3'b101});
        $display("tx dut=%0d reps=%0d hold=%0d busy_cycles=%0d", sel, r, hold, len);
    endtask

    task automatic idle_cycles(input int sel, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            chk($sformatf("%s_idle%0d", tag, i), {29'd0, obs3(sel)}, {29'd0, 3'b100});
        end
    endtask

    initial begin
        int   last_sel;
        logic last_hold;

        // Reset held with start high: nothing may begin.
        reset = 1'b1;
        bus_a.start = 1'b1; bus_a.reps = '0;
        bus_b.start = 1'b1; bus_b.reps = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk($sformatf("rst_a%0d", i), {29'd0, obs3(0)}, {29'd0, 3'b100});
            chk($sformatf("rst_b%0d", i), {29'd0, obs3(1)}, {29'd0, 3'b100});
        end
        reset = 1'b0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        idle_cycles(0, 2, "post_rst_a");
        idle_cycles(1, 1, "post_rst_b");

        // Directed single, repeat and zero-repeat transmissions.
        run_tx(0, 1, 1'b0);
        idle_cycles(0, 2, "a1");
        run_tx(0, 2, 1'b0);
        idle_cycles(0, 1, "a2");
        run_tx(0, 0, 1'b0);
        idle_cycles(0, 1, "a0");

        // start held during busy, then accepted in the done cycle.
        run_tx(0, 1, 1'b1);
        run_tx(0, 2, 1'b0);
        idle_cycles(0, 2, "chain");

        // Reset at the second pattern bit aborts without done.
        set_start(0, 1'b1);
        set_reps(0, REP_W'(2));
        @(negedge clock);
        chk("abort_bit0", {29'd0, obs3(0)}, {29'd0, 3'b010});
        set_start(0, 1'b0);
        @(negedge clock);
        chk("abort_bit1", {29'd0, obs3(0)}, {29'd0, 3'b110});
        reset = 1'b1;
        @(negedge clock);
        chk("abort_rst", {29'd0, obs3(0)}, {29'd0, 3'b100});
        reset = 1'b0;
        idle_cycles(0, 3, "abort");
        run_tx(0, 1, 1'b0);

        // Variant instance: contiguous 1010 patterns.
        idle_cycles(1, 1, "b_pre");
        run_tx(1, 3, 1'b0);
        idle_cycles(1, 1, "b3");
        run_tx(1, 0, 1'b0);

        // Randomized transmissions, including chained ones.
        last_sel  = 1;
        last_hold = 1'b0;
        for (int it = 0; it < 14; it++) begin
            int   sel;
            int   r;
            logic hold;
            sel  = last_hold ? last_sel : int'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 15));
            hold = (it == 13) ? 1'b0 : logic'($urandom_range(0, 1));
            if (!last_hold) idle_cycles(sel, int'($urandom_range(0, 3)), $sformatf("rnd%0d", it));
            run_tx(sel, r, hold);
            last_sel  = sel;
            last_hold = hold;
        end
        set_start(0, 1'b0);
        set_start(1, 1'b0);
        idle_cycles(0, 2, "end_a");
        idle_cycles(1, 1, "end_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial pattern transmitter. It emits a fixed PAT_W-bit pattern, MSB first, on a one-bit line. The default pattern is 0,1,1.
- Each pattern is followed by GAP idle cycles, and the pattern-plus-gap unit repeats a requested number of times.
- It drives the serial input of the "011" sequence recognizer in the serial test subsystem.
- The idle line level is 1, so the recognizer rests in its initial state.
- The default GAP=4 covers the recognizer's 4-clock output hold. This realigns the recognizer before the next pattern.

Parameters:
- PAT_W, 3: pattern length in bits, ≥1.
- PATTERN, 'B011: pattern bits, transmitted bit PAT_W-1 first.
- GAP, 4: idle-1 cycles after each pattern, ≥0.
- REP_W, 4: width of the repeat-count input.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset, sampled on posedge clock.
- start  in  1  request to transmit; sampled only in IDLE.
- reps  in  REP_W  number of pattern repetitions; 0 is treated as 1.
- out  out  1  serial data line; registered.
- busy  out  1  high while a transmission (patterns + gaps) is in progress.
- done  out  1  one-cycle pulse when a transmission completes.

Behaviour:
- Single clock. reset is synchronous and active-high. All outputs are registered.
- Reset values: out=1, busy=0, done=0, state=IDLE, all counters 0. reset has priority over every other input, including mid-transmission; the transmission is aborted and no done pulse is generated.
- States:
  - IDLE: out=1, busy=0.
  - SEND: out = current pattern bit.
  - GAP: out=1.
- Counters:
  - BITCNT, ceil(log2(PAT_W+1)) bits: pattern bits still to send.
  - GAPCNT, sized for GAP: gap cycles still to send.
  - REPCNT, REP_W bits: repetitions still to send.
- IDLE, start=1 at posedge:
  - Latch REPCNT = (reps==0) ? 1 : reps.
  - Go to SEND and load BITCNT=PAT_W.
  - In the same edge, out = PATTERN[PAT_W-1] and busy=1.
  - Latency start→first bit = 1 cycle.
- IDLE, start=0: remain in IDLE; out=1.
- SEND:
  - Each posedge advances one bit.
  - After the LSB has been on out for one cycle:
    - GAP>0: go to GAP with GAPCNT=GAP; out=1.
    - GAP=0 and REPCNT>1: decrement REPCNT and restart SEND with the MSB; no idle cycle.
    - GAP=0 and REPCNT==1: go to IDLE.
- GAP:
  - out=1 for exactly GAP cycles.
  - Then REPCNT>1: decrement REPCNT and return to SEND with the MSB.
  - Then REPCNT==1: go to IDLE.
- Completion:
  - On entry to IDLE from SEND/GAP: busy=0 and done=1 for exactly one cycle.
  - busy is high for exactly N*(PAT_W+GAP) cycles, where N is the effective repeat count.
- start while busy=1: ignored, with no queueing and no effect on counters.
- start=1 in the done cycle: accepted, since the state is IDLE. This gives back-to-back transmissions, with out going from the last gap bit straight to the new MSB.
- reps changes after acceptance have no effect.
- REPCNT maximum is 2^REP_W-1. There is no wrap, because REPCNT only decrements to 1 and 0 is never loaded.
- done and busy are never high in the same cycle.

Test Plan:
1. Reset: assert reset for 2 cycles with start=1 → out=1, busy=0, done=0. No transmission starts until reset=0 and start is sampled again.
2. Single send, reps=1, defaults: start pulse at edge k.
   - out from k+1 = 0,1,1,1,1,1,1.
   - busy high for cycles k+1..k+7.
   - done=1 at cycle k+8 only.
   - A connected recognizer raises its output for 4 cycles.
3. Repeat, reps=2: out = 0,1,1,1,1,1,1,0,1,1,1,1,1,1, busy high 14 cycles, single done pulse. reps=0 gives the same waveform as reps=1.
4. start held high during busy → no disturbance. start=1 in the done cycle → the new MSB 0 appears on the next cycle.
5. Reset mid-operation: assert reset at the second pattern bit → next cycle out=1, busy=0, no done. A subsequent start produces a full clean pattern.
6. Parameter variant, PATTERN='B1010, PAT_W=4, GAP=0, reps=3 → out = 1,0,1,0 ×3 contiguous, busy high 12 cycles, then done.
